// File: rtl/seq_add_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor that processes CHUNK bits per clock and
// ripples the carry between chunks through a register. Valid/ready on both sides.
module seq_add_sub #(
    parameter int WIDTH = 6,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NSTEP = WIDTH / CHUNK;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [SW-1:0] LAST = SW'(NSTEP - 1);

    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("seq_add_sub: illegal WIDTH/CHUNK combination");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b;
    logic             carry;
    logic [SW-1:0]    step;

    logic [CHUNK-1:0] a_ch, b_ch;
    logic [CHUNK:0]   sum;
    logic             msb_cin;
    logic [WIDTH-1:0] z_upd;
    logic             last_step;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last_step = (step == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One chunk slice per cycle; carry into the slice MSB recovered from a^b^sum.
    always_comb begin
        a_ch    = op_a[step*CHUNK +: CHUNK];
        b_ch    = op_b[step*CHUNK +: CHUNK];
        sum     = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};
        msb_cin = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ sum[CHUNK-1];
        z_upd   = z;
        z_upd[step*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            step      <= '0;
            z         <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= b ^ {WIDTH{sub}};
                        carry <= sub | carry_in;
                        step  <= '0;
                    end
                end
                CALC: begin
                    z     <= z_upd;
                    carry <= sum[CHUNK];
                    step  <= step + SW'(1);
                    if (last_step) begin
                        carry_out <= sum[CHUNK];
                        overflow  <= msb_cin ^ sum[CHUNK];
                        zero      <= (z_upd == '0);
                        negative  <= z_upd[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_add_sub.sv
// Bench for seq_add_sub: CHUNK=1, 2 and 6 instances (WIDTH=6) driven in lockstep and
// checked every cycle against an arithmetic model plus hand-computed vectors.
module tb_seq_add_sub;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       sub = 1'b0;
    logic       carry_in = 1'b0;
    logic       out_ready = 1'b0;
    logic [5:0] a = '0;
    logic [5:0] b = '0;

    logic [2:0] rdy, vld, cout, ovf, zf, neg;
    logic [5:0] zo [3];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_add_sub #(.WIDTH(6), .CHUNK(1)) u_c1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in), .out_valid(vld[0]),
        .out_ready(out_ready), .z(zo[0]), .carry_out(cout[0]), .overflow(ovf[0]),
        .zero(zf[0]), .negative(neg[0]));

    seq_add_sub #(.WIDTH(6), .CHUNK(2)) u_c2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in), .out_valid(vld[1]),
        .out_ready(out_ready), .z(zo[1]), .carry_out(cout[1]), .overflow(ovf[1]),
        .zero(zf[1]), .negative(neg[1]));

    seq_add_sub #(.WIDTH(6), .CHUNK(6)) u_c6 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in), .out_valid(vld[2]),
        .out_ready(out_ready), .z(zo[2]), .carry_out(cout[2]), .overflow(ovf[2]),
        .zero(zf[2]), .negative(neg[2]));

    // Result packing used throughout: {negative, zero, overflow, carry_out, z}
    function automatic logic [9:0] dut_res(input int i);
        return {neg[i], zf[i], ovf[i], cout[i], zo[i]};
    endfunction

    function automatic int nstep(input int i);
        return (i == 0) ? 6 : (i == 1) ? 3 : 1;
    endfunction

    function automatic logic [9:0] calc(input logic [5:0] x, input logic [5:0] y,
                                        input logic s, input logic ci);
        int ux, uy, sx, sy, full, sres;
        logic [5:0] r;
        logic c, o;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            full = ux - uy + 64;
            sres = sx - sy;
        end else begin
            full = ux + uy + int'(ci);
            sres = sx + sy + int'(ci);
        end
        r = 6'(full % 64);
        c = (full >= 64);
        o = (sres > 31) || (sres < -32);
        return {r[5], (r == 6'd0), o, c, r};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: phase 0 idle, 1 computing, 2 result held
    int         m_ph  [3];
    int         m_rem [3];
    logic [9:0] m_pend[3];
    logic [9:0] m_last[3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                m_ph[i]   = 0;
                m_rem[i]  = 0;
                m_last[i] = '0;
            end else if (m_ph[i] == 2) begin
                if (out_ready) m_ph[i] = 0;
            end else if (m_ph[i] == 1) begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_ph[i]   = 2;
                    m_last[i] = m_pend[i];
                end
            end else if (in_valid) begin
                m_pend[i] = calc(a, b, sub, carry_in);
                m_rem[i]  = nstep(i);
                m_ph[i]   = 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                chk($sformatf("reset in_ready dut%0d", i), 32'(rdy[i]), 32'd1);
                chk($sformatf("reset out_valid dut%0d", i), 32'(vld[i]), 32'd0);
                chk($sformatf("reset outputs dut%0d", i), 32'(dut_res(i)), 32'd0);
            end else begin
                chk($sformatf("model in_ready dut%0d", i), 32'(rdy[i]), 32'(m_ph[i] == 0));
                chk($sformatf("model out_valid dut%0d", i), 32'(vld[i]), 32'(m_ph[i] == 2));
                if (m_ph[i] != 1)
                    chk($sformatf("model result dut%0d", i), 32'(dut_res(i)), 32'(m_last[i]));
            end
        end
    end

    task automatic do_op(input logic [5:0] ta, input logic [5:0] tb, input logic ts,
                         input logic tc, input logic [9:0] exp, input int hold,
                         input bit pulse, input string nm);
        int lat [3];
        int cyc;
        lat = '{-1, -1, -1};
        @(negedge clk);
        a = ta; b = tb; sub = ts; carry_in = tc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        if (pulse) begin
            a = ~ta; b = ~tb; sub = ~ts; carry_in = ~tc; in_valid = 1'b1;
        end
        cyc = 0;
        while (cyc < 20 && vld != 3'b111) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b0;
            for (int i = 0; i < 3; i++)
                if (vld[i] && lat[i] < 0) lat[i] = cyc;
        end
        chk({nm, " all valid"}, 32'(vld), 32'b111);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s latency dut%0d", nm, i), 32'(lat[i]), 32'(nstep(i)));
            chk($sformatf("%s result dut%0d", nm, i), 32'(dut_res(i)), 32'(exp));
        end
        repeat (hold) begin
            @(negedge clk);
            chk({nm, " hold valid"}, 32'(vld), 32'b111);
            chk({nm, " hold in_ready"}, 32'(rdy), 32'b000);
            for (int i = 0; i < 3; i++)
                chk($sformatf("%s hold result dut%0d", nm, i), 32'(dut_res(i)), 32'(exp));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " idle in_ready"}, 32'(rdy), 32'b111);
        chk({nm, " idle out_valid"}, 32'(vld), 32'b000);
        if (pulse) begin
            @(negedge clk);
            chk({nm, " not queued"}, 32'(vld), 32'b000);
            chk({nm, " still idle"}, 32'(rdy), 32'b111);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        // Pin the model against hand-computed values
        chk("model 5+3",    32'(calc(6'd5,  6'd3, 1'b0, 1'b0)), 32'({4'b0000, 6'd8}));
        chk("model 31+1",   32'(calc(6'd31, 6'd1, 1'b0, 1'b0)), 32'({4'b1010, 6'd32}));
        chk("model 3-5",    32'(calc(6'd3,  6'd5, 1'b1, 1'b0)), 32'({4'b1000, 6'd62}));
        chk("model 5-5",    32'(calc(6'd5,  6'd5, 1'b1, 1'b1)), 32'({4'b0101, 6'd0}));
        chk("model 63+0+1", 32'(calc(6'd63, 6'd0, 1'b0, 1'b1)), 32'({4'b0101, 6'd0}));
        chk("model 32-1",   32'(calc(6'd32, 6'd1, 1'b1, 1'b0)), 32'({4'b0011, 6'd31}));

        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", 32'(rdy), 32'b111);
        chk("post-reset out_valid", 32'(vld), 32'b000);
        for (int i = 0; i < 3; i++)
            chk($sformatf("post-reset outputs dut%0d", i), 32'(dut_res(i)), 32'd0);

        do_op(6'd5,  6'd3, 1'b0, 1'b0, {4'b0000, 6'd8},  0, 1'b0, "add 5+3");
        do_op(6'd31, 6'd1, 1'b0, 1'b0, {4'b1010, 6'd32}, 0, 1'b0, "add 31+1");
        do_op(6'd3,  6'd5, 1'b1, 1'b0, {4'b1000, 6'd62}, 0, 1'b0, "sub 3-5");
        do_op(6'd5,  6'd5, 1'b1, 1'b1, {4'b0101, 6'd0},  0, 1'b0, "sub 5-5");
        do_op(6'd63, 6'd0, 1'b0, 1'b1, {4'b0101, 6'd0},  0, 1'b0, "add 63+0+1");
        do_op(6'd32, 6'd1, 1'b1, 1'b0, {4'b0011, 6'd31}, 0, 1'b0, "sub 32-1");
        do_op(6'd5,  6'd3, 1'b0, 1'b0, {4'b0000, 6'd8},  4, 1'b1, "stall+pulse");

        // Abort an operation mid-calculation with an async reset
        @(negedge clk);
        a = 6'd5; b = 6'd3; sub = 1'b0; carry_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async reset in_ready", 32'(rdy), 32'b111);
        chk("async reset out_valid", 32'(vld), 32'b000);
        for (int i = 0; i < 3; i++)
            chk($sformatf("async reset outputs dut%0d", i), 32'(dut_res(i)), 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        do_op(6'd10, 6'd20, 1'b0, 1'b0, {4'b0000, 6'd30}, 0, 1'b0, "add 10+20");

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
